ee457_mem_responder: RTL and testbench
======================================

// Module: ee457_mem_responder
// PURPOSE
// - Memory-side responder for the CPU's split instruction/data memory interface: serves imem fetches and
//   dmem loads/stores with the exact timing the pipeline expects (combinational read, write on clk edge).
// - Contains a program/data loader FSM (valid/ready word stream) that fills both arrays after reset while
//   holding the CPU via cpu_hold. It also has sticky protocol-error flags and saturating access counters for the benches.
// PARAMETERS
// - AW     10   word-index width; each array holds 2**AW 32-bit words (byte range 0 .. 4*2**AW-1)
// - CNT_W  16   width of dmem access counters
// PORTS
// - clk         in   1     clock; all state updates on posedge
// - rst         in   1     reset, synchronous, active-high
// - imem_addr   in   32    byte address of fetch
// - imem_wdata  in   32    unused write data (CPU drives 0)
// - imemread    in   1     fetch request
// - imemwrite   in   1     must be 0; any 1 in RUN is a protocol error
// - imem_rdata  out  32    fetched word, combinational
// - dmem_addr   in   32    byte address of load/store
// - dmem_wdata  in   32    store data
// - dmemread    in   1     load request
// - dmemwrite   in   1     store request
// - dmem_rdata  out  32    load data, combinational
// - ld_valid    in   1     loader beat valid
// - ld_ready    out  1     loader beat accepted when ld_valid&ld_ready at posedge
// - ld_sel      in   1     target of beat: 0=imem array, 1=dmem array
// - ld_data     in   32    word to write
// - ld_last     in   1     final beat of image
// - cpu_hold    out  1     1 = CPU must be held in reset (loading)
// - err_flags   out  4    sticky {ovf, proto, range, misalign}
// - dmem_rd_cnt out  CNT_W saturating count of qualified loads
// - dmem_wr_cnt out  CNT_W saturating count of qualified stores
// BEHAVIOUR
// - FSM states LOAD, RUN. rst (any time, incl. mid-load or mid-run) -> LOAD, ptr_i=ptr_d=0, err_flags=0,
//   counters=0. Array contents are never cleared by rst.
// - LOAD: ld_ready=1, cpu_hold=1, imem_rdata=dmem_rdata=0, CPU-side requests ignored (no flags, no counts).
//   Accepted beat writes ld_data to array[ld_sel] at ptr_sel, then ptr_sel+1 mod 2**AW. Wrap from
//   2**AW-1 to 0 sets err ovf. Accepted beat with ld_last=1 -> RUN at that edge.
// - RUN: ld_ready=0, cpu_hold=0; ld_valid ignored. No path back to LOAD except rst.
// - Word index = addr[AW+1:2]. In range iff addr[31:AW+2]==0. Aligned iff addr[1:0]==0.
// - imem_rdata = imemread & in-range ? imem[idx] : 0 (misaligned still reads idx, sets misalign).
// - dmem_rdata = dmemread & in-range ? dmem[idx] : 0; same misalign rule.
// - Store: at posedge if RUN & dmemwrite & aligned & in-range -> dmem[idx]<=dmem_wdata. Misaligned or
//   out-of-range store is dropped and sets the corresponding flag.
// - Read of the address being stored in the same cycle returns OLD data; new data visible next cycle.
// - dmemread&dmemwrite same cycle: store performed, read returns old data, proto flag set, both counted.
// - imemwrite=1 in RUN: ignored, proto flag set.
// - Flags set at posedge following the offending cycle; sticky until rst.
// - Counters +1 per RUN cycle with dmemread (resp. dmemwrite) high and address aligned & in range; hold at
//   2**CNT_W-1 (no wrap).
// - Zero-latency reads; write latency 1 edge; loader throughput 1 word/cycle.
// TESTING
// - rst, load imem beats 0x20080005,0x20090003 then dmem beat 0xDEADBEEF ld_last -> cpu_hold falls
//   next cycle, imem_rdata@0x4=0x20090003, dmem_rdata@0x0=0xDEADBEEF.
// - RUN store 0x12345678 to 0x10 with dmemread same addr -> same cycle 0 (old), next cycle 0x12345678,
//   proto flag=1, wr_cnt=1, rd_cnt=1.
// - dmem store to 0x13 and load from 4*2**AW -> store dropped, dmem_rdata=0, err_flags=4'b0011.
// - 2**AW+1 imem beats -> ptr wraps, word 0 holds last beat, ovf flag=1.
// - rst asserted mid-load after 3 beats -> ld_ready=1, reload from ptr 0; previous words retained until overwritten.
// - CNT_W=4, 20 aligned loads -> dmem_rd_cnt saturates at 15.

Source files
------------

// File: rtl/ee457_mem_responder.sv
// Split imem/dmem responder for the CPU pipeline: combinational reads, clocked stores,
// a valid/ready image loader that holds the CPU, sticky protocol-error flags and access counters.
module ee457_mem_responder #(
  parameter int AW    = 10,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       imem_addr,
  input  logic [31:0]       imem_wdata,
  input  logic              imemread,
  input  logic              imemwrite,
  output logic [31:0]       imem_rdata,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic              dmemread,
  input  logic              dmemwrite,
  output logic [31:0]       dmem_rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              cpu_hold,
  output logic [3:0]        err_flags,
  output logic [CNT_W-1:0]  dmem_rd_cnt,
  output logic [CNT_W-1:0]  dmem_wr_cnt
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [31:0] imem_mem [2**AW];
  logic [31:0] dmem_mem [2**AW];

  state_t           state_q, state_d;
  logic             ld_ready_q, ld_ready_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic [AW-1:0]    ptr_i_q, ptr_i_d;
  logic [AW-1:0]    ptr_d_q, ptr_d_d;
  logic [3:0]       err_q, err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic [AW-1:0] i_idx, d_idx;
  logic          i_inrange, d_inrange;
  logic          i_align, d_align;
  logic          run;
  logic          ld_fire;
  logic          dmem_we;
  logic          d_req;
  logic          mis_hit, rng_hit, proto_hit;
  logic          unused_imem_wdata;

  assign unused_imem_wdata = ^imem_wdata;

  assign i_idx     = imem_addr[AW+1:2];
  assign d_idx     = dmem_addr[AW+1:2];
  assign i_inrange = (imem_addr[31:AW+2] == '0);
  assign d_inrange = (dmem_addr[31:AW+2] == '0);
  assign i_align   = (imem_addr[1:0] == 2'b00);
  assign d_align   = (dmem_addr[1:0] == 2'b00);

  assign run     = (state_q == RUN);
  assign ld_fire = ld_valid & ld_ready_q;
  assign d_req   = dmemread | dmemwrite;
  assign dmem_we = run & dmemwrite & d_align & d_inrange;

  // Misaligned reads still return the word at the truncated index; only the flag records it.
  assign imem_rdata = (run && imemread && i_inrange) ? imem_mem[i_idx] : 32'h0;
  assign dmem_rdata = (run && dmemread && d_inrange) ? dmem_mem[d_idx] : 32'h0;

  assign mis_hit   = (imemread & ~i_align) | (d_req & ~d_align);
  assign rng_hit   = (imemread & ~i_inrange) | (d_req & ~d_inrange);
  assign proto_hit = imemwrite | (dmemread & dmemwrite);

  assign ld_ready    = ld_ready_q;
  assign cpu_hold    = cpu_hold_q;
  assign err_flags   = err_q;
  assign dmem_rd_cnt = rd_cnt_q;
  assign dmem_wr_cnt = wr_cnt_q;

  always_comb begin
    state_d    = state_q;
    ld_ready_d = ld_ready_q;
    cpu_hold_d = cpu_hold_q;
    ptr_i_d    = ptr_i_q;
    ptr_d_d    = ptr_d_q;
    err_d      = err_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;

    if (ld_fire) begin
      if (!ld_sel) begin
        ptr_i_d = ptr_i_q + PTR_ONE;
        if (&ptr_i_q) err_d[3] = 1'b1;
      end else begin
        ptr_d_d = ptr_d_q + PTR_ONE;
        if (&ptr_d_q) err_d[3] = 1'b1;
      end
      if (ld_last) begin
        state_d    = RUN;
        ld_ready_d = 1'b0;
        cpu_hold_d = 1'b0;
      end
    end

    // CPU-side requests only matter once the image is loaded.
    if (run) begin
      err_d = err_q | {1'b0, proto_hit, rng_hit, mis_hit};
      if (dmemread && d_align && d_inrange)  rd_cnt_d = sat_inc(rd_cnt_q);
      if (dmemwrite && d_align && d_inrange) wr_cnt_d = sat_inc(wr_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      ld_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      ptr_i_q    <= '0;
      ptr_d_q    <= '0;
      err_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      cpu_hold_q <= cpu_hold_d;
      ptr_i_q    <= ptr_i_d;
      ptr_d_q    <= ptr_d_d;
      err_q      <= err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Array contents survive reset; a reset cycle only blocks writes from landing.
  always_ff @(posedge clk) begin
    if (!rst && ld_fire && !ld_sel) imem_mem[ptr_i_q] <= ld_data;
    if (!rst && ld_fire && ld_sel)  dmem_mem[ptr_d_q] <= ld_data;
    if (!rst && dmem_we)            dmem_mem[d_idx]   <= dmem_wdata;
  end

endmodule

// File: tb/tb_ee457_mem_responder.sv
// Directed bench for ee457_mem_responder: loader, run-time accesses, error flags, counters.
module tb_ee457_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, ld_data;
  logic        imemread, imemwrite, dmemread, dmemwrite;
  logic        ld_valid, ld_sel, ld_last;

  logic [31:0] imem_rdata, dmem_rdata;
  logic        ld_ready, cpu_hold;
  logic [3:0]  err_flags;
  logic [15:0] dmem_rd_cnt, dmem_wr_cnt;

  logic [31:0] imem_rdata2, dmem_rdata2;
  logic        ld_ready2, cpu_hold2;
  logic [3:0]  err_flags2;
  logic [3:0]  dmem_rd_cnt2, dmem_wr_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ee457_mem_responder #(.AW(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imemread(imemread), .imemwrite(imemwrite),
    .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmemread(dmemread), .dmemwrite(dmemwrite),
    .dmem_rdata(dmem_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_hold(cpu_hold), .err_flags(err_flags),
    .dmem_rd_cnt(dmem_rd_cnt), .dmem_wr_cnt(dmem_wr_cnt)
  );

  ee457_mem_responder #(.AW(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imemread(imemread), .imemwrite(imemwrite),
    .imem_rdata(imem_rdata2),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmemread(dmemread), .dmemwrite(dmemwrite),
    .dmem_rdata(dmem_rdata2),
    .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_sel(ld_sel), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_hold(cpu_hold2), .err_flags(err_flags2),
    .dmem_rd_cnt(dmem_rd_cnt2), .dmem_wr_cnt(dmem_wr_cnt2)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_addr = '0; imem_wdata = '0; imemread = 1'b0; imemwrite = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmemread = 1'b0; dmemwrite = 1'b0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_data = '0; ld_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one beat; the following posedge accepts it (ld_ready is high throughout LOAD).
  task automatic send_beat(input logic sel, input logic [31:0] data, input logic last);
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = sel; ld_data = data; ld_last = last;
  endtask

  task automatic end_load();
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
    tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
    tests++; if (err_flags !== 4'b0000) begin fails++; $display("FAIL reset_err: got %b expected 0000", err_flags); end
    tests++; if (dmem_rd_cnt !== 16'd0 || dmem_wr_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", dmem_rd_cnt, dmem_wr_cnt); end
    imemread = 1'b1; dmemread = 1'b1;
    #1;
    tests++; if (imem_rdata !== 32'h0 || dmem_rdata !== 32'h0) begin fails++; $display("FAIL load_reads_zero: got %h/%h expected 0/0", imem_rdata, dmem_rdata); end
    imemread = 1'b0; dmemread = 1'b0;
  endtask

  task automatic test_load_and_run();
    send_beat(1'b0, 32'h2008_0005, 1'b0);
    send_beat(1'b0, 32'h2009_0003, 1'b0);
    send_beat(1'b1, 32'hDEAD_BEEF, 1'b0);
    for (int i = 1; i <= 4; i++) send_beat(1'b1, 32'h0, i == 4);
    end_load();
    tests++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0) begin fails++; $display("FAIL run_entry: got hold=%b ready=%b expected 0/0", cpu_hold, ld_ready); end
    imemread = 1'b1; imem_addr = 32'h4; dmemread = 1'b1; dmem_addr = 32'h0;
    #1;
    tests++; if (imem_rdata !== 32'h2009_0003) begin fails++; $display("FAIL imem_0x4: got %h expected 20090003", imem_rdata); end
    tests++; if (dmem_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL dmem_0x0: got %h expected deadbeef", dmem_rdata); end
    imem_addr = 32'h0;
    #1;
    tests++; if (imem_rdata !== 32'h2008_0005) begin fails++; $display("FAIL imem_0x0: got %h expected 20080005", imem_rdata); end
    imemread = 1'b0; dmemread = 1'b0;
  endtask

  task automatic test_store_same_cycle();
    @(negedge clk);
    dmem_addr = 32'h10; dmem_wdata = 32'h1234_5678; dmemwrite = 1'b1; dmemread = 1'b1;
    #1;
    tests++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL store_old_data: got %h expected 0", dmem_rdata); end
    @(negedge clk);
    dmemwrite = 1'b0;
    #1;
    tests++; if (dmem_rdata !== 32'h1234_5678) begin fails++; $display("FAIL store_new_data: got %h expected 12345678", dmem_rdata); end
    tests++; if (err_flags !== 4'b0100) begin fails++; $display("FAIL rdwr_proto: got %b expected 0100", err_flags); end
    tests++; if (dmem_wr_cnt !== 16'd1 || dmem_rd_cnt !== 16'd1) begin fails++; $display("FAIL rdwr_counts: got wr=%0d rd=%0d expected 1/1", dmem_wr_cnt, dmem_rd_cnt); end
    dmemread = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    send_beat(1'b0, 32'h0000_0013, 1'b1);
    end_load();
    dmem_addr = 32'h13; dmem_wdata = 32'hCAFE_F00D; dmemwrite = 1'b1;
    @(negedge clk);
    dmemwrite = 1'b0; dmemread = 1'b1; dmem_addr = 32'h1000;
    #1;
    tests++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL range_read_zero: got %h expected 0", dmem_rdata); end
    @(negedge clk);
    dmemread = 1'b0;
    tests++; if (err_flags !== 4'b0011) begin fails++; $display("FAIL range_misalign_flags: got %b expected 0011", err_flags); end
    tests++; if (dmem_rd_cnt !== 16'd0 || dmem_wr_cnt !== 16'd0) begin fails++; $display("FAIL bad_access_counts: got rd=%0d wr=%0d expected 0/0", dmem_rd_cnt, dmem_wr_cnt); end
    dmemread = 1'b1; dmem_addr = 32'h10;
    #1;
    tests++; if (dmem_rdata !== 32'h1234_5678) begin fails++; $display("FAIL store_dropped: got %h expected 12345678", dmem_rdata); end
    dmemread = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 1024; i++) send_beat(1'b0, 32'hA000_0000 + 32'(i), i == 1024);
    end_load();
    tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL wrap_run: got hold=%b expected 0", cpu_hold); end
    tests++; if (err_flags !== 4'b1000) begin fails++; $display("FAIL wrap_ovf: got %b expected 1000", err_flags); end
    imemread = 1'b1; imem_addr = 32'h0;
    #1;
    tests++; if (imem_rdata !== 32'hA000_0400) begin fails++; $display("FAIL wrap_word0: got %h expected a0000400", imem_rdata); end
    imem_addr = 32'h4;
    #1;
    tests++; if (imem_rdata !== 32'hA000_0001) begin fails++; $display("FAIL wrap_word1: got %h expected a0000001", imem_rdata); end
    imem_addr = 32'hFFC;
    #1;
    tests++; if (imem_rdata !== 32'hA000_03FF) begin fails++; $display("FAIL wrap_word1023: got %h expected a00003ff", imem_rdata); end
    imemread = 1'b0;
  endtask

  task automatic test_mid_load_reset();
    do_reset();
    send_beat(1'b0, 32'h11, 1'b0);
    send_beat(1'b0, 32'h22, 1'b0);
    send_beat(1'b0, 32'h33, 1'b0);
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin fails++; $display("FAIL midload_rst: got ready=%b hold=%b expected 1/1", ld_ready, cpu_hold); end
    send_beat(1'b0, 32'h44, 1'b1);
    end_load();
    imemread = 1'b1; imem_addr = 32'h0;
    #1;
    tests++; if (imem_rdata !== 32'h44) begin fails++; $display("FAIL reload_ptr0: got %h expected 44", imem_rdata); end
    imem_addr = 32'h4;
    #1;
    tests++; if (imem_rdata !== 32'h22) begin fails++; $display("FAIL retained_w1: got %h expected 22", imem_rdata); end
    imem_addr = 32'h8;
    #1;
    tests++; if (imem_rdata !== 32'h33) begin fails++; $display("FAIL retained_w2: got %h expected 33", imem_rdata); end
    imemread = 1'b0;
  endtask

  task automatic test_counter_sat();
    do_reset();
    send_beat(1'b1, 32'h55, 1'b1);
    end_load();
    dmemread = 1'b1; dmem_addr = 32'h0;
    #1;
    tests++; if (dmem_rdata2 !== 32'h55) begin fails++; $display("FAIL small_read: got %h expected 55", dmem_rdata2); end
    repeat (20) @(negedge clk);
    dmemread = 1'b0;
    tests++; if (dmem_rd_cnt2 !== 4'd15) begin fails++; $display("FAIL rd_cnt_sat: got %0d expected 15", dmem_rd_cnt2); end
    tests++; if (dmem_rd_cnt !== 16'd20) begin fails++; $display("FAIL rd_cnt_wide: got %0d expected 20", dmem_rd_cnt); end
    tests++; if (dmem_wr_cnt2 !== 4'd0) begin fails++; $display("FAIL wr_cnt_idle: got %0d expected 0", dmem_wr_cnt2); end
    imemwrite = 1'b1;
    @(negedge clk);
    imemwrite = 1'b0;
    tests++; if (err_flags2 !== 4'b0100) begin fails++; $display("FAIL imemwrite_proto: got %b expected 0100", err_flags2); end
  endtask

  initial begin
    test_reset();
    test_load_and_run();
    test_store_same_cycle();
    test_errors();
    test_wrap();
    test_mid_load_reset();
    test_counter_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
